// File: rtl/bit_serializer_pkg.sv
// Shared types and width helpers for the parallel-to-serial stage feeding the "101" detector.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        GAP
    } state_e;

    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = $clog2(GAP_MAX + 1);

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel word in, one bit per clock out on sel/sel_valid, optional idle gap between words.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity (XOR) bit after every word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sel,
    output logic              sel_valid,
    output logic              busy
);

    localparam int                   CNT_W    = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      sreg_q, sreg_d;
    logic [CNT_W-1:0]       bcnt_q, bcnt_d;
    logic [GAP_CNT_W-1:0]   gcnt_q, gcnt_d;
    logic                   sel_q, sel_d;
    logic                   sel_valid_q, sel_valid_d;
    logic                   word_done;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic                   par_q, par_d;
`endif

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        din_ready   = 1'b0;
        word_done   = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            IDLE: begin
                din_ready   = 1'b1;
                sel_d       = 1'b0;
                sel_valid_d = 1'b0;
            end
            SHIFT: begin
                if (bcnt_q != '0) begin
                    sel_d       = head_bit(sreg_q);
                    sel_valid_d = 1'b1;
                    sreg_d      = advance(sreg_q);
                    bcnt_d      = bcnt_q - CNT_W'(1);
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d     = PARITY;
                    sel_d       = par_q;
                    sel_valid_d = 1'b1;
`else
                    // Last data bit on the wire: a new word may chain in with no bubble.
                    din_ready   = (GAP_CYCLES == 0);
                    word_done   = 1'b1;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                din_ready = (GAP_CYCLES == 0);
                word_done = 1'b1;
            end
`endif
            GAP: begin
                sel_d       = 1'b0;
                sel_valid_d = 1'b0;
                if (gcnt_q == '0) state_d = IDLE;
                else              gcnt_d  = gcnt_q - GAP_CNT_W'(1);
            end
            default: begin
                state_d     = IDLE;
                sel_d       = 1'b0;
                sel_valid_d = 1'b0;
            end
        endcase

        if (word_done) begin
            sel_d       = 1'b0;
            sel_valid_d = 1'b0;
            if (GAP_CYCLES > 0) begin
                state_d = GAP;
                gcnt_d  = GAP_LOAD;
            end else begin
                state_d = IDLE;
            end
        end

        // The head bit goes straight to sel so it appears the cycle after the accept.
        if (din_valid && din_ready) begin
            state_d     = SHIFT;
            sel_d       = head_bit(din);
            sel_valid_d = 1'b1;
            sreg_d      = advance(din);
            bcnt_d      = LAST_IDX;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_d       = ^din;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            sel_q       <= 1'b0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = (state_q != IDLE);

endmodule
